mult_div_ctrl: RTL and testbench

- Sequencing controller and iterative engine for the shared multiply/divide resource used by the EX stage.
- Starts an operation when EX presents MULT/MULTU/DIV/DIVU, iterates one bit per cycle, then presents a 64-bit result with a done flag.
- EX holds its stall request while done is low, and writes HI/LO from the result once done is high.
- Handles signed fix-up, divide-by-zero, pipeline flush, and downstream stalls, so one instruction never executes twice.

---
 rtl/mult_div_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mult_div_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// Sequencing controller and one-bit-per-cycle engine for the shared MULT/MULTU/DIV/DIVU resource.
// Magnitudes are iterated unsigned; the sign fix-up is applied on the last iteration edge.
module mult_div_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              funct,
    input  logic [DATA_WIDTH-1:0]   operand_1,
    input  logic [DATA_WIDTH-1:0]   operand_2,
    input  logic                    flush,
    input  logic                    pipeline_stall,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    busy,
    output logic [1:0]              state_dbg
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]        ONE_CNT  = 1;
    localparam logic [DATA_WIDTH-1:0]   ONE_W    = 1;
    localparam logic [2*DATA_WIDTH-1:0] ONE_2W   = 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_counter;
    logic [DATA_WIDTH-1:0]   r_op_a;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic                    r_is_div;
    logic                    r_sign_q;
    logic                    r_sign_r;
    logic [2*DATA_WIDTH-1:0] r_result;
    logic                    r_done;
    logic                    r_busy;

    logic                    w_is_md;
    logic                    w_is_div_f;
    logic                    w_is_signed_f;
    logic                    w_neg1;
    logic                    w_neg2;
    logic [DATA_WIDTH-1:0]   w_mag1;
    logic [DATA_WIDTH-1:0]   w_mag2;
    logic                    w_div_zero;
    logic                    w_start;
    logic [DATA_WIDTH-1:0]   w_acc_hi;
    logic [DATA_WIDTH-1:0]   w_acc_lo;
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [DATA_WIDTH:0]     w_mul_top;
    logic [2*DATA_WIDTH-1:0] w_mul_next;
    logic [DATA_WIDTH:0]     w_div_part;
    logic [DATA_WIDTH:0]     w_div_diff;
    logic                    w_div_ge;
    logic [2*DATA_WIDTH-1:0] w_div_next;
    logic [2*DATA_WIDTH-1:0] w_acc_next;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0]   w_quot_fix;
    logic [DATA_WIDTH-1:0]   w_rem_fix;
    logic [2*DATA_WIDTH-1:0] w_final;
    logic [1:0]              w_state_next;

    // funct 0x18..0x1B share bits [5:2]; bit1 selects divide, bit0 selects unsigned.
    assign w_is_md       = (funct[5:2] == 4'b0110);
    assign w_is_div_f    = funct[1];
    assign w_is_signed_f = ~funct[0];
    assign w_neg1        = w_is_signed_f & operand_1[DATA_WIDTH-1];
    assign w_neg2        = w_is_signed_f & operand_2[DATA_WIDTH-1];
    assign w_mag1        = w_neg1 ? (~operand_1 + ONE_W) : operand_1;
    assign w_mag2        = w_neg2 ? (~operand_2 + ONE_W) : operand_2;
    assign w_div_zero    = w_is_div_f && (operand_2 == '0);
    assign w_start       = !flush && w_is_md;

    assign w_acc_hi = r_acc[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_acc_lo = r_acc[DATA_WIDTH-1:0];

    // Multiply: r_op_a is the multiplicand, the low half of r_acc holds the multiplier bits still to consume.
    assign w_mul_sum  = {1'b0, w_acc_hi} + {1'b0, r_op_a};
    assign w_mul_top  = r_acc[0] ? w_mul_sum : {1'b0, w_acc_hi};
    assign w_mul_next = {w_mul_top, w_acc_lo[DATA_WIDTH-1:1]};

    // Divide: r_op_a is the divisor, high half is the partial remainder, low half shifts dividend out / quotient in.
    assign w_div_part = {w_acc_hi, w_acc_lo[DATA_WIDTH-1]};
    assign w_div_diff = w_div_part - {1'b0, r_op_a};
    assign w_div_ge   = (w_div_part >= {1'b0, r_op_a});
    assign w_div_next = w_div_ge
                      ? {w_div_diff[DATA_WIDTH-1:0], w_acc_lo[DATA_WIDTH-2:0], 1'b1}
                      : {w_div_part[DATA_WIDTH-1:0], w_acc_lo[DATA_WIDTH-2:0], 1'b0};

    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    assign w_prod_fix = r_sign_q ? (~w_acc_next + ONE_2W) : w_acc_next;
    assign w_quot_fix = r_sign_q ? (~w_acc_next[DATA_WIDTH-1:0] + ONE_W)
                                 : w_acc_next[DATA_WIDTH-1:0];
    assign w_rem_fix  = r_sign_r ? (~w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH] + ONE_W)
                                 : w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_final    = r_is_div ? {w_rem_fix, w_quot_fix} : w_prod_fix;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = w_div_zero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else if (r_counter == LAST_CNT) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // A held stall keeps the result presented; funct is not re-decoded here.
                if (flush || !pipeline_stall) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_counter <= '0;
            r_op_a    <= '0;
            r_acc     <= '0;
            r_is_div  <= 1'b0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next == S_DONE);
            r_busy  <= (w_state_next == S_BUSY);
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op_a    <= w_is_div_f ? w_mag2 : w_mag1;
                        r_acc     <= {{DATA_WIDTH{1'b0}}, (w_is_div_f ? w_mag1 : w_mag2)};
                        r_is_div  <= w_is_div_f;
                        r_sign_q  <= w_neg1 ^ w_neg2;
                        r_sign_r  <= w_neg1;
                        r_counter <= '0;
                        if (w_div_zero) begin
                            r_result <= {operand_1, {DATA_WIDTH{1'b1}}};
                        end
                    end
                end
                S_BUSY: begin
                    if (!flush) begin
                        r_acc     <= w_acc_next;
                        r_counter <= r_counter + ONE_CNT;
                        if (r_counter == LAST_CNT) begin
                            r_result <= w_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done      = r_done;
    assign busy      = r_busy;
    assign result    = r_result;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: a reference model pushes expected results at issue,
// and each completion pops and compares them along with latency and busy/done timing.
module tb_mult_div_ctrl;

    localparam int W = 32;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_NOP   = 6'h20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [5:0]     funct = F_NOP;
    logic [W-1:0]   operand_1 = '0;
    logic [W-1:0]   operand_2 = '0;
    logic           flush = 1'b0;
    logic           pipeline_stall = 1'b0;
    logic           done;
    logic [2*W-1:0] result;
    logic           busy;
    logic [1:0]     state_dbg;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_exp = '0;
    int             n_checks = 0;
    int             n_bad = 0;

    mult_div_ctrl #(.DATA_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .funct          (funct),
        .operand_1      (operand_1),
        .operand_2      (operand_2),
        .flush          (flush),
        .pipeline_stall (pipeline_stall),
        .done           (done),
        .result         (result),
        .busy           (busy),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint         sa;
        longint         sb;
        logic [2*W-1:0] ua;
        logic [2*W-1:0] ub;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        case (f)
            F_MULT:  return 64'(sa * sb);
            F_MULTU: return ua * ub;
            F_DIV: begin
                if (b == '0) return {a, {W{1'b1}}};
                q = W'(sa / sb);
                r = W'(sa % sb);
                return {r, q};
            end
            F_DIVU: begin
                if (b == '0) return {a, {W{1'b1}}};
                q = W'(ua / ub);
                r = W'(ua % ub);
                return {r, q};
            end
            default: return '0;
        endcase
    endfunction

    // Presents an instruction in the current cycle (called #1 after a rising edge).
    task automatic launch(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        funct     = f;
        operand_1 = a;
        operand_2 = b;
        if (push) exp_q.push_back(model(f, a, b));
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input bit drop_funct);
        int             cyc;
        int             nbusy;
        logic [2*W-1:0] exp;
        cyc   = 0;
        nbusy = 0;
        while (cyc < exp_lat + 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (drop_funct && cyc == 1) funct = F_NOP;
            if (done) break;
            if (busy) nbusy++;
        end
        check_eq({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check_eq({tag, "_busycnt"}, 64'(nbusy), 64'(exp_lat - 1));
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        if (exp_q.size() == 0) begin
            check_eq({tag, "_q_empty"}, 64'(1), 64'(0));
        end else begin
            exp = exp_q.pop_front();
            last_exp = exp;
            check_eq({tag, "_res"}, result, exp);
        end
    endtask

    task automatic after_done(input string tag);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_drop"}, 64'(done), 64'(0));
        check_eq({tag, "_res_hold"}, result, last_exp);
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        lat = (f[1] && b == '0) ? 1 : W + 1;
        launch(f, a, b, 1'b1);
        wait_done(tag, lat, 1'b1);
        after_done(tag);
    endtask

    initial begin
        bit       seen;
        logic [5:0]   rf;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_result", result, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("multu_max_const", last_exp, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd7);
        check_eq("mult_neg_const", last_exp, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2);
        check_eq("div_neg_const", last_exp, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_small", F_DIVU, 32'd100, 32'd7);
        check_eq("divu_small_const", last_exp, 64'h0000_0002_0000_000E);
        run_op("divu_zero", F_DIVU, 32'h0000_1234, 32'd0);
        check_eq("divu_zero_const", last_exp, 64'h0000_1234_FFFF_FFFF);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("div_ovf_const", last_exp, 64'h0000_0000_8000_0000);
        run_op("mult_min", F_MULT, 32'h8000_0000, 32'h8000_0000);
        check_eq("mult_min_const", last_exp, 64'h4000_0000_0000_0000);
        run_op("div_zero_s", F_DIV, 32'hFFFF_0001, 32'd0);

        // Flush in the middle of a multiply: no completion, result keeps the last value.
        launch(F_MULT, 32'd12345, 32'hFFFF_FFF7, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) funct = F_NOP;
        end
        check_eq("flush_busy_before", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'(0));
        check_eq("flush_done", 64'(done), 64'(0));
        check_eq("flush_res", result, last_exp);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check_eq("flush_quiet", 64'(seen), 64'(0));
        run_op("multu_after_flush", F_MULTU, 32'd5, 32'd6);
        check_eq("multu_after_flush_const", last_exp, 64'd30);

        // Downstream stall holds DONE with funct still a MULT code; no restart afterwards.
        launch(F_MULT, 32'hFFFE_7960, 32'd70000, 1'b1);
        wait_done("stall_mult", W + 1, 1'b0);
        pipeline_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_eq("stall_done", 64'(done), 64'(1));
            check_eq("stall_busy", 64'(busy), 64'(0));
            check_eq("stall_res", result, last_exp);
        end
        pipeline_stall = 1'b0;
        @(posedge clk);
        #1;
        check_eq("stall_release_done", 64'(done), 64'(0));
        check_eq("stall_no_restart", 64'(busy), 64'(0));
        launch(F_DIVU, 32'd1000000, 32'd37, 1'b1);
        wait_done("b2b_divu", W + 1, 1'b1);
        after_done("b2b_divu");

        // Asynchronous reset while BUSY with counter at 15.
        launch(F_MULT, 32'd77, 32'hFFFF_FFFB, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) funct = F_NOP;
        end
        check_eq("pre_rst_busy", 64'(busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_done", 64'(done), 64'(0));
        check_eq("arst_busy", 64'(busy), 64'(0));
        check_eq("arst_result", result, '0);
        @(negedge clk);
        rst = 1'b0;
        last_exp = '0;
        @(posedge clk);
        #1;
        run_op("post_rst_mult", F_MULT, 32'hFFFF_FFB3, 32'd5);

        for (int i = 0; i < 8; i++) begin
            rf = F_MULT + 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            run_op("rand_op", rf, ra, rb);
        end

        check_eq("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
